mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs in the pipelined RV32 CPU.
- Turns load/store info into a req/ack transaction on the data-memory port: byte-lane alignment, load extraction/extension, misalignment detection.
- Selects the writeback value and registers it into the MEM/WB outputs.
- Asserts a stall while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: cycles to wait for dmem_ack before aborting. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mem_alu_out_in  in  32  ALU result / effective address
- mem_rv2_in  in  32  store data, unaligned (data in low bytes)
- mem_dwe_in  in  4  store byte enables, unshifted: 0001 byte, 0011 half, 1111 word, 0000 no store
- mem_func3_in  in  3  load/store width and sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- mem_mem_reg_in  in  1  instruction is a load
- mem_reg_wr_in  in  1  register write enable
- mem_rd_in  in  5  destination register
- mem_reg_in_sel_in  in  2  writeback select: 00 alu, 01 load, 10 pc4, 11 imm
- mem_pc4_in  in  32  PC+4
- mem_imm_in  in  32  immediate
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-shifted store data
- dmem_be  out  4  lane-shifted byte enables
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  one-cycle completion pulse
- mem_stall  out  1  hold PC/IF/ID/EX/EX-MEM this cycle
- wb_data_out  out  32  writeback value (registered)
- wb_rd_out  out  5  destination (registered)
- wb_reg_wr_out  out  1  write enable (registered)
- mem_misalign_out  out  1  one-cycle pulse for a misaligned access (registered)
- mem_buserr_out  out  1  one-cycle pulse for a timeout abort (registered; constant 0 without the feature)

Behaviour:
- Access condition: access = mem_mem_reg_in | (|mem_dwe_in). With access = 0 the slot is a pass-through or bubble.
- Misalignment: half access with addr[0] = 1, or word access with addr[1:0] != 0.
  - The access is treated as a non-access; no request is issued.
  - Next cycle: mem_misalign_out = 1 and wb_reg_wr_out = 0.
- Store lanes: dmem_be = mem_dwe_in << addr[1:0]; dmem_wdata = mem_rv2_in << (8*addr[1:0]).
- Load extract: shifted = dmem_rdata >> (8*addr[1:0]).
  - lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw uses the word as is.
  - func3 011, 110 or 111 on a load gives 0.
- FSM states IDLE, BUSY, DONE:
  - IDLE, aligned access: mem_stall = 1 combinationally. Latch addr/wdata/be/we into dmem_* registers, then go to BUSY. WB outputs are written as a bubble (reg_wr 0).
  - IDLE, no access or misaligned: mem_stall = 0. WB outputs take the selected value next edge (latency 1).
  - BUSY: dmem_req = 1, dmem_addr/wdata/be/we held stable, mem_stall = 1.
    - On dmem_ack, capture the extracted load data into an internal register and go to DONE.
  - DONE: mem_stall = 0; dmem_req = 0. At the edge, WB outputs take the final value (load data if sel = 01), then go to IDLE.
    - The EX/MEM inputs are still the same instruction because upstream was frozen.
  - A dmem_ack seen outside BUSY is ignored.
- Writeback mux: 00 alu_out, 01 load data, 10 pc4, 11 imm.
  - wb_reg_wr_out = mem_reg_wr_in for a completed slot; forced to 0 on stall/bubble cycles, misalign and bus error.
  - rd = 0 is passed through as is; the register file ignores x0.
- Stores: wb_reg_wr_out = mem_reg_wr_in (normally 0). Completion is on ack, same as loads.
- Back-to-back accesses: DONE→IDLE, so each access costs at least 3 cycles; the next instruction is evaluated in IDLE.
- Reset (synchronous, any state including BUSY):
  - state IDLE; dmem_req/we/be = 0; dmem_addr/wdata = 0.
  - all wb_* = 0; mem_misalign_out and mem_buserr_out = 0.
  - An outstanding request is dropped; a later ack is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack: drop req, go to DONE with the load value 0, wb_reg_wr_out = 0, and pulse mem_buserr_out = 1 for one cycle.
  - An ack on the same cycle as the timeout wins.
- Undefined: no counter; BUSY waits indefinitely; mem_buserr_out is tied to 0.

Test Plan:
- ALU op: alu_out = 0x12345678, sel = 00, rd = 5, reg_wr = 1, no access → next edge wb_data = 0x12345678, rd 5, reg_wr 1; mem_stall never asserted.
- lb at addr 0x103, rdata 0x80FFFFFF, ack after 2 wait cycles → dmem_addr = 0x100, req held 3 cycles, stall high in IDLE+BUSY; wb_data = 0xFFFFFF80, reg_wr 1.
- lhu at addr 0x202, rdata 0xBEEF1234 → wb_data = 0x0000BEEF.
- sh at addr 0x2, rv2 = 0x0000ABCD, dwe = 0011 → dmem_be = 1100, dmem_wdata = 0xABCD0000, dmem_we = 1; wb_reg_wr = 0.
- lw at addr 0x101 → no dmem_req, mem_misalign_out pulses 1 cycle, wb_reg_wr 0, no stall.
- Reset asserted in BUSY with req = 1 → next edge dmem_req = 0, state IDLE, wb_* = 0; a later ack has no effect. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4 and no ack → req drops after 4 BUSY cycles, mem_buserr_out pulses.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory request/ack port between the memory stage (master) and the data memory (slave).
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage of the RV32 pipeline: data-memory req/ack sequencing, lane alignment, MEM/WB register.
// Optional bus-timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        mem_alu_out_in,
    input  logic [31:0]        mem_rv2_in,
    input  logic [3:0]         mem_dwe_in,
    input  logic [2:0]         mem_func3_in,
    input  logic               mem_mem_reg_in,
    input  logic               mem_reg_wr_in,
    input  logic [4:0]         mem_rd_in,
    input  logic [1:0]         mem_reg_in_sel_in,
    input  logic [31:0]        mem_pc4_in,
    input  logic [31:0]        mem_imm_in,
    mem_access_unit_if.master  dmem,
    output logic               mem_stall,
    output logic [31:0]        wb_data_out,
    output logic [4:0]         wb_rd_out,
    output logic               wb_reg_wr_out,
    output logic               mem_misalign_out,
    output logic               mem_buserr_out
);
    // state | meaning
    // IDLE  | evaluate the EX/MEM slot; aligned access launches a request
    // BUSY  | request outstanding, waiting for ack (or timeout)
    // DONE  | transaction finished, write back the final value
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e      state_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] load_q;
    logic        err_q;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_rd_q;
    logic        wb_reg_wr_q;
    logic        misalign_q;
    logic        buserr_q;

    logic [1:0]  off;
    logic        access;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        access_ok;
    logic [31:0] shifted;
    logic [31:0] load_d;
    logic [31:0] wb_data_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        timeout;

    assign off    = mem_alu_out_in[1:0];
    assign access = mem_mem_reg_in | (|mem_dwe_in);

    // Width comes from func3 for loads and from the byte-enable pattern for stores.
    always_comb begin
        is_half = 1'b0;
        is_word = 1'b0;
        if (mem_mem_reg_in) begin
            is_half = (mem_func3_in == 3'b001) || (mem_func3_in == 3'b101);
            is_word = (mem_func3_in == 3'b010);
        end else begin
            is_half = (mem_dwe_in == 4'b0011);
            is_word = (mem_dwe_in == 4'b1111);
        end
    end

    assign misaligned = access & ((is_half & off[0]) | (is_word & (off != 2'b00)));
    assign access_ok  = access & ~misaligned;

    assign be_d    = mem_dwe_in << off;
    assign wdata_d = mem_rv2_in << {off, 3'b000};
    assign shifted = dmem.dmem_rdata >> {off, 3'b000};

    always_comb begin
        load_d = '0;
        case (mem_func3_in)
            3'b000:  load_d = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_d = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_d = shifted;
            3'b100:  load_d = {24'b0, shifted[7:0]};
            3'b101:  load_d = {16'b0, shifted[15:0]};
            default: load_d = '0;
        endcase
    end

    always_comb begin
        wb_data_d = mem_imm_in;
        case (mem_reg_in_sel_in)
            2'b00:   wb_data_d = mem_alu_out_in;
            2'b01:   wb_data_d = load_q;
            2'b10:   wb_data_d = mem_pc4_in;
            default: wb_data_d = mem_imm_in;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q;

    // Counter sits at zero outside BUSY, so it is clear on every BUSY entry.
    always_ff @(posedge clk) begin
        if (reset || (state_q != BUSY)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout = (state_q == BUSY) && !dmem.dmem_ack &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            load_q      <= '0;
            err_q       <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_reg_wr_q <= 1'b0;
            misalign_q  <= 1'b0;
            buserr_q    <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access_ok) begin
                        state_q     <= BUSY;
                        req_q       <= 1'b1;
                        we_q        <= |mem_dwe_in;
                        addr_q      <= {mem_alu_out_in[31:2], 2'b00};
                        wdata_q     <= wdata_d;
                        be_q        <= be_d;
                        err_q       <= 1'b0;
                        wb_reg_wr_q <= 1'b0;
                    end else begin
                        wb_data_q   <= wb_data_d;
                        wb_rd_q     <= mem_rd_in;
                        wb_reg_wr_q <= mem_reg_wr_in & ~misaligned;
                        misalign_q  <= misaligned;
                    end
                end
                BUSY: begin
                    wb_reg_wr_q <= 1'b0;
                    if (dmem.dmem_ack) begin
                        load_q  <= load_d;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (timeout) begin
                        load_q  <= '0;
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Upstream was frozen, so the EX/MEM inputs still describe this access.
                    wb_data_q   <= wb_data_d;
                    wb_rd_q     <= mem_rd_in;
                    wb_reg_wr_q <= mem_reg_wr_in & ~err_q;
                    buserr_q    <= err_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_stall = (state_q == BUSY) || ((state_q == IDLE) && access_ok);

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    assign wb_data_out      = wb_data_q;
    assign wb_rd_out        = wb_rd_q;
    assign wb_reg_wr_out    = wb_reg_wr_q;
    assign mem_misalign_out = misalign_q;
    assign mem_buserr_out   = buserr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized slots against a behavioural model.
module tb_mem_access_unit;
    logic        clk;
    logic        reset;
    logic [31:0] mem_alu_out_in;
    logic [31:0] mem_rv2_in;
    logic [3:0]  mem_dwe_in;
    logic [2:0]  mem_func3_in;
    logic        mem_mem_reg_in;
    logic        mem_reg_wr_in;
    logic [4:0]  mem_rd_in;
    logic [1:0]  mem_reg_in_sel_in;
    logic [31:0] mem_pc4_in;
    logic [31:0] mem_imm_in;
    logic        mem_stall;
    logic [31:0] wb_data_out;
    logic [4:0]  wb_rd_out;
    logic        wb_reg_wr_out;
    logic        mem_misalign_out;
    logic        mem_buserr_out;

    int errors = 0;
    int checks = 0;

    mem_access_unit_if dif ();

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_alu_out_in    (mem_alu_out_in),
        .mem_rv2_in        (mem_rv2_in),
        .mem_dwe_in        (mem_dwe_in),
        .mem_func3_in      (mem_func3_in),
        .mem_mem_reg_in    (mem_mem_reg_in),
        .mem_reg_wr_in     (mem_reg_wr_in),
        .mem_rd_in         (mem_rd_in),
        .mem_reg_in_sel_in (mem_reg_in_sel_in),
        .mem_pc4_in        (mem_pc4_in),
        .mem_imm_in        (mem_imm_in),
        .dmem              (dif),
        .mem_stall         (mem_stall),
        .wb_data_out       (wb_data_out),
        .wb_rd_out         (wb_rd_out),
        .wb_reg_wr_out     (wb_reg_wr_out),
        .mem_misalign_out  (mem_misalign_out),
        .mem_buserr_out    (mem_buserr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned acc_size(input logic ld, input logic [2:0] f3, input logic [3:0] dwe);
        if (ld) return (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 1;
        return (dwe == 4'b0011) ? 2 : (dwe == 4'b1111) ? 4 : 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [2:0] f3);
        int unsigned w, b, h;
        w = rdata >> (8 * addr[1:0]);
        b = w & 32'hFF;
        h = w & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [31:0] addr, input logic [31:0] rv2, input logic [3:0] dwe,
                         input logic [2:0] f3, input logic ld, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [31:0] pc4, input logic [31:0] imm);
        mem_alu_out_in    = addr;
        mem_rv2_in        = rv2;
        mem_dwe_in        = dwe;
        mem_func3_in      = f3;
        mem_mem_reg_in    = ld;
        mem_reg_wr_in     = rw;
        mem_rd_in         = rd;
        mem_reg_in_sel_in = sel;
        mem_pc4_in        = pc4;
        mem_imm_in        = imm;
    endtask

    // Presents one slot (called just after a rising edge) and follows it to its writeback.
    task automatic run_instr(input logic [31:0] addr, input logic [31:0] rv2, input logic [3:0] dwe,
                             input logic [2:0] f3, input logic ld, input logic rw, input logic [4:0] rd,
                             input logic [1:0] sel, input logic [31:0] pc4, input logic [31:0] imm,
                             input logic [31:0] rdata, input int waits);
        logic        acc, mis;
        logic [31:0] exp_wb, exp_ld;
        drive(addr, rv2, dwe, f3, ld, rw, rd, sel, pc4, imm);
        acc = ld || (dwe != 4'b0000);
        mis = acc && ((addr % acc_size(ld, f3, dwe)) != 0);
        exp_ld = model_load(rdata, addr, f3);
        exp_wb = (sel == 2'd0) ? addr : (sel == 2'd1) ? exp_ld : (sel == 2'd2) ? pc4 : imm;
        if (!acc || mis) begin
            dif.dmem_ack   = 1'($urandom_range(0, 1));
            dif.dmem_rdata = $urandom;
            #1;
            check_val("stall_pass", mem_stall, 1'b0);
            @(posedge clk); #1;
            dif.dmem_ack = 1'b0;
            check_val("req_pass", dif.dmem_req, 1'b0);
            check_val("misalign", mem_misalign_out, mis);
            check_val("wb_wr_pass", wb_reg_wr_out, rw && !mis);
            if (!mis) begin
                check_val("wb_data_pass", wb_data_out, exp_wb);
                check_val("wb_rd_pass", wb_rd_out, rd);
            end
        end else begin
            dif.dmem_ack = 1'b0;
            #1;
            check_val("stall_idle", mem_stall, 1'b1);
            @(posedge clk); #1;
            check_val("req_busy", dif.dmem_req, 1'b1);
            check_val("addr", dif.dmem_addr, addr & 32'hFFFF_FFFC);
            check_val("we", dif.dmem_we, dwe != 4'b0000);
            check_val("be", dif.dmem_be, (int'(dwe) << addr[1:0]) & 15);
            check_val("wdata", dif.dmem_wdata, rv2 << (8 * addr[1:0]));
            check_val("wb_wr_bubble", wb_reg_wr_out, 1'b0);
            check_val("stall_busy", mem_stall, 1'b1);
            for (int i = 0; i < waits; i++) begin
                @(posedge clk); #1;
                check_val("req_hold", dif.dmem_req, 1'b1);
                check_val("stall_hold", mem_stall, 1'b1);
            end
            dif.dmem_rdata = rdata;
            dif.dmem_ack   = 1'b1;
            @(posedge clk); #1;
            dif.dmem_ack   = 1'b0;
            dif.dmem_rdata = $urandom;
            check_val("req_done", dif.dmem_req, 1'b0);
            check_val("stall_done", mem_stall, 1'b0);
            check_val("wb_wr_busy", wb_reg_wr_out, 1'b0);
            @(posedge clk); #1;
            check_val("wb_data_acc", wb_data_out, exp_wb);
            check_val("wb_rd_acc", wb_rd_out, rd);
            check_val("wb_wr_acc", wb_reg_wr_out, rw);
            check_val("buserr_acc", mem_buserr_out, 1'b0);
        end
    endtask

    initial begin
        logic [1:0]  sel_tbl [3];
        logic [2:0]  ld_tbl  [7];
        int          kind, w;
        logic [31:0] a;
        logic [3:0]  dwe;
        logic [2:0]  f3;
        sel_tbl = '{2'd0, 2'd2, 2'd3};
        ld_tbl  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

        reset = 1'b1;
        dif.dmem_ack   = 1'b0;
        dif.dmem_rdata = '0;
        drive(32'h0, 32'h0, 4'b0000, 3'd0, 1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_req", dif.dmem_req, 1'b0);
        check_val("rst_be", dif.dmem_be, 4'b0000);
        check_val("rst_wb_data", wb_data_out, 32'h0);
        check_val("rst_wb_wr", wb_reg_wr_out, 1'b0);
        check_val("rst_misalign", mem_misalign_out, 1'b0);
        check_val("rst_buserr", mem_buserr_out, 1'b0);
        reset = 1'b0;

        // ALU pass-through, lb with two wait cycles, lhu, sh lanes, misaligned lw
        run_instr(32'h1234_5678, 32'h0, 4'b0000, 3'd0, 1'b0, 1'b1, 5'd5, 2'd0, 32'h4, 32'h8, 32'h0, 0);
        run_instr(32'h0000_0103, 32'h0, 4'b0000, 3'd0, 1'b1, 1'b1, 5'd7, 2'd1, 32'h4, 32'h8, 32'h80FF_FFFF, 2);
        run_instr(32'h0000_0202, 32'h0, 4'b0000, 3'd5, 1'b1, 1'b1, 5'd9, 2'd1, 32'h4, 32'h8, 32'hBEEF_1234, 1);
        run_instr(32'h0000_0002, 32'h0000_ABCD, 4'b0011, 3'd1, 1'b0, 1'b0, 5'd0, 2'd0, 32'h4, 32'h8, 32'h0, 0);
        run_instr(32'h0000_0101, 32'h0, 4'b0000, 3'd2, 1'b1, 1'b1, 5'd3, 2'd1, 32'h4, 32'h8, 32'h0, 0);

        // Reset while a request is outstanding; a later ack must not revive it
        drive(32'h40, 32'h0, 4'b0000, 3'd2, 1'b1, 1'b1, 5'd4, 2'd1, 32'h4, 32'h8);
        @(posedge clk); #1;
        check_val("rst_busy_req", dif.dmem_req, 1'b1);
        reset = 1'b1;
        drive(32'h0, 32'h0, 4'b0000, 3'd0, 1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check_val("rst_busy_req_drop", dif.dmem_req, 1'b0);
        check_val("rst_busy_idle", mem_stall, 1'b0);
        check_val("rst_busy_wb_rd", wb_rd_out, 5'd0);
        check_val("rst_busy_wb_wr", wb_reg_wr_out, 1'b0);
        reset = 1'b0;
        dif.dmem_ack = 1'b1;
        @(posedge clk); #1;
        dif.dmem_ack = 1'b0;
        check_val("late_ack_req", dif.dmem_req, 1'b0);
        check_val("late_ack_stall", mem_stall, 1'b0);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 2);
            a    = $urandom;
            case (kind)
                0: run_instr(a, $urandom, 4'b0000, 3'($urandom), 1'b0, 1'($urandom), 5'($urandom),
                             sel_tbl[$urandom_range(0, 2)], $urandom, $urandom, $urandom, 0);
                1: run_instr(a, $urandom, 4'b0000, ld_tbl[$urandom_range(0, 6)], 1'b1, 1'($urandom),
                             5'($urandom), 2'd1, $urandom, $urandom, $urandom, $urandom_range(0, 3));
                default: begin
                    w   = $urandom_range(0, 2);
                    dwe = (w == 0) ? 4'b0001 : (w == 1) ? 4'b0011 : 4'b1111;
                    f3  = 3'(w);
                    run_instr(a, $urandom, dwe, f3, 1'b0, ($urandom_range(0, 3) == 0), 5'($urandom),
                              sel_tbl[$urandom_range(0, 2)], $urandom, $urandom, $urandom,
                              $urandom_range(0, 3));
                end
            endcase
        end

`ifdef MEM_TIMEOUT_EN
        drive(32'h80, 32'h0, 4'b0000, 3'd2, 1'b1, 1'b1, 5'd6, 2'd1, 32'h4, 32'h8);
        dif.dmem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_val("to_req_hold", dif.dmem_req, 1'b1);
        end
        @(posedge clk); #1;
        check_val("to_req_drop", dif.dmem_req, 1'b0);
        check_val("to_stall_done", mem_stall, 1'b0);
        @(posedge clk); #1;
        check_val("to_buserr", mem_buserr_out, 1'b1);
        check_val("to_wb_wr", wb_reg_wr_out, 1'b0);
        drive(32'h0, 32'h0, 4'b0000, 3'd0, 1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check_val("to_buserr_pulse", mem_buserr_out, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
